cp0_unit: RTL
=============

// Module: cp0_unit
// PURPOSE
//  Coprocessor-0 for the MIPS core; consumes the control decoder's copWr/instruction outputs and feeds the PC mux and writeback mux.
//  Holds Count/Compare/Status/Cause/EPC, detects SYSCALL and masked interrupts, and redirects the PC to the handler or back via ERET.
//  Sits beside the register file; rdata is the memtoReg=2'b10 writeback source.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0080  handler address driven on pc_redirect for any exception
//  COUNT_DIV   2              core cycles per Count increment (>=1)
//  PRID        32'h0001_8000  read-only value of reg 15
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  ins          in   32  instruction committing this cycle
//  copWr        in   2   from control decoder; 2'b01 = MTC0/SYSCALL/ERET this cycle
//  pc           in   32  address of ins
//  wdata        in   32  rt value for MTC0
//  ext_int      in   5   asynchronous level interrupt lines
//  rdata        out  32  CP0 reg selected by ins[15:11] (MFC0 data)
//  redirect     out  1   PC mux select: take pc_redirect next
//  pc_redirect  out  32  EXC_VECTOR on exception, EPC on ERET
//  inst_kill    out  1   suppress regWr/memWr of ins (interrupt taken)
//  timer_irq    out  1   Cause.IP7 (debug/LED)
// BEHAVIOUR
//  Regs: Count(9), Compare(11), Status(12)={IM[15:8],EXL[1],IE[0]}, Cause(13)={IP[15:8],ExcCode[6:2]},
//   EPC(14), PRId(15)=PRID; other bits and regs read 0; rdata combinational, no latency.
//  Reset: all regs 0, sync flops 0, divider 0; outputs redirect=0, inst_kill=0, timer_irq=0, rdata=reg(ins[15:11]).
//  Decode (only when copWr==2'b01): MTC0 = op 010000, rs 00100; ERET = op 010000, rs 10000, func 011000;
//   SYSCALL = op 000000, func 001100. copWr!=01 -> no CP0 write/exception from ins.
//  ext_int: 2-flop synchroniser, IP[6:2] = synced level (not latched); IP[1:0] software-writable via MTC0 Cause.
//  Timer: divider counts 0..COUNT_DIV-1; at wrap Count<=Count+1 (mod 2^32); if the new Count==Compare, IP7<=1.
//   IP7 is cleared only by MTC0 to Compare. MTC0 Compare same edge as match: write wins, IP7=0.
//   MTC0 Count reloads Count and clears the divider that edge.
//  int_pend = IE & ~EXL & |(IP & IM), from registered values (combinational).
//  Priority per cycle: interrupt > SYSCALL > ERET > MTC0.
//  Interrupt: redirect=1, pc_redirect=EXC_VECTOR, inst_kill=1 (ins incl. any MTC0 discarded);
//   edge: EPC<=pc, ExcCode<=0, EXL<=1.
//  SYSCALL: redirect=1, pc_redirect=EXC_VECTOR, inst_kill=0; edge: EPC<=pc, ExcCode<=8, EXL<=1.
//   Handler must advance EPC by 4 before ERET.
//  ERET: redirect=1, pc_redirect=EPC (current value); edge: EXL<=0. No interrupt possible in same cycle (EXL=1).
//  MTC0: writes wdata to reg ins[15:11] at edge; writes to 9/11/12/13(IP[1:0] only)/14; others ignored.
//   Status write with pending interrupt unmasked takes effect next cycle (1-cycle latency to int_pend).
//  Exception while EXL=1: no interrupt; SYSCALL still overwrites EPC/ExcCode (nested syscall unsupported).
//  Reset asserted mid-handler: all state to reset values immediately; redirect drops to 0 asynchronously.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all regs 0, redirect=0, MFC0 of 12/13/14 reads 0, reg 15 reads PRID.
//  2 MTC0 Status=32'h0000_8001 then MFC0 12 -> 32'h0000_8001; MTC0 to reg 3 -> reads 0.
//  3 SYSCALL at pc=32'h0000_0040 -> same cycle redirect=1, pc_redirect=32'h80; next EPC=0x40, Cause[6:2]=8, EXL=1;
//    ERET -> pc_redirect=0x40, EXL=0.
//  4 Timer: Status=0x8001, Compare=10, COUNT_DIV=2 -> IP7=1 20 cycles after Count=0;
//    interrupt taken with inst_kill=1, EPC=killed pc; MTC0 Compare clears IP7.
//  5 Simultaneous: ext_int[0] pending+enabled while SYSCALL commits -> interrupt wins, ExcCode=0, EPC=SYSCALL pc.
//  6 MTC0 Compare on the exact match edge -> IP7 stays 0; ext_int pulse -> IP2 visible 2 cycles later, drops after.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor 0: Count/Compare timer, Status/Cause/EPC, SYSCALL and interrupt entry, ERET return.
// rdata is the MFC0 writeback source; redirect/pc_redirect steer the PC mux.
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] PRID       = 32'h0001_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic [1:0]  copWr,
    input  logic [31:0] pc,
    input  logic [31:0] wdata,
    input  logic [4:0]  ext_int,
    output logic [31:0] rdata,
    output logic        redirect,
    output logic [31:0] pc_redirect,
    output logic        inst_kill,
    output logic        timer_irq
);

    localparam int unsigned     DivW    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(COUNT_DIV - 1);

    // Instruction fields
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rd;
    logic [5:0] func;
    logic       cop_active;
    logic       is_mtc0;
    logic       is_eret;
    logic       is_syscall;
    logic       unused_ins;

    assign op         = ins[31:26];
    assign rs         = ins[25:21];
    assign rd         = ins[15:11];
    assign func       = ins[5:0];
    assign unused_ins = ^{ins[20:16], ins[10:6]};

    assign cop_active = (copWr == 2'b01);
    assign is_mtc0    = cop_active && (op == 6'b010000) && (rs == 5'b00100);
    assign is_eret    = cop_active && (op == 6'b010000) && (rs == 5'b10000) && (func == 6'b011000);
    assign is_syscall = cop_active && (op == 6'b000000) && (func == 6'b001100);

    // Architectural state
    logic [31:0]     count_q, count_d;
    logic [31:0]     compare_q, compare_d;
    logic [7:0]      im_q, im_d;
    logic            exl_q, exl_d;
    logic            ie_q, ie_d;
    logic            ip7_q, ip7_d;
    logic [1:0]      ipsw_q, ipsw_d;
    logic [4:0]      exccode_q, exccode_d;
    logic [31:0]     epc_q, epc_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      sync1_q;
    logic [4:0]      sync2_q;

    logic [7:0] ip;
    logic       int_pend;

    // IP[6:2] follow the synchronised lines directly; nothing latches them.
    assign ip       = {ip7_q, sync2_q, ipsw_q};
    assign int_pend = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        ip7_d     = ip7_q;
        ipsw_d    = ipsw_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        div_d     = div_q;

        if (div_q == DivLast) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
            if (count_d == compare_q) begin
                ip7_d = 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        // An interrupt discards whatever ins was, including an MTC0.
        if (int_pend) begin
            epc_d     = pc;
            exccode_d = 5'd0;
            exl_d     = 1'b1;
        end else if (is_syscall) begin
            epc_d     = pc;
            exccode_d = 5'd8;
            exl_d     = 1'b1;
        end else if (is_eret) begin
            exl_d = 1'b0;
        end else if (is_mtc0) begin
            case (rd)
                5'd9: begin
                    count_d = wdata;
                    div_d   = '0;
                end
                5'd11: begin
                    compare_d = wdata;
                    ip7_d     = 1'b0;
                end
                5'd12: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                5'd13:   ipsw_d = wdata[9:8];
                5'd14:   epc_d  = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            ip7_q     <= 1'b0;
            ipsw_q    <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
            div_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            ip7_q     <= ip7_d;
            ipsw_q    <= ipsw_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            div_q     <= div_d;
            sync1_q   <= ext_int;
            sync2_q   <= sync1_q;
        end
    end

    // rst_n gates redirect so the PC mux is released as soon as reset asserts.
    always_comb begin
        redirect    = rst_n & (int_pend | is_syscall | is_eret);
        inst_kill   = rst_n & int_pend;
        pc_redirect = (int_pend || is_syscall) ? EXC_VECTOR : epc_q;
        timer_irq   = ip7_q;
    end

    always_comb begin
        case (rd)
            5'd9:    rdata = count_q;
            5'd11:   rdata = compare_q;
            5'd12:   rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
            5'd13:   rdata = {16'b0, ip, 1'b0, exccode_q, 2'b0};
            5'd14:   rdata = epc_q;
            5'd15:   rdata = PRID;
            default: rdata = 32'd0;
        endcase
    end

endmodule
